// File: rtl/countdown_ctrl.sv
// MM:SS countdown controller: BCD digit entry, start/pause on the start button's
// rising edge, one-second decrement while running, and a DONE state at 00:00.
module countdown_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       set_mode,
  input  logic       load_a,
  input  logic       load_b,
  input  logic       load_c,
  input  logic       load_d,
  input  logic [3:0] digit_in,
  input  logic       start_btn,
  output logic [3:0] min_t,
  output logic [3:0] min_u,
  output logic [3:0] sec_t,
  output logic [3:0] sec_u,
  output logic       running,
  output logic       done,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    READY = 3'd2,
    RUN   = 3'd3,
    PAUSE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t     state;
  logic       start_btn_q;
  logic       start_pulse;
  logic       count_zero;
  logic       count_one;
  logic [3:0] dec_mt, dec_mu, dec_st, dec_su;

  function automatic logic [3:0] sat9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [3:0] sat5(input logic [3:0] d);
    return (d > 4'd5) ? 4'd5 : d;
  endfunction

  assign start_pulse = start_btn & ~start_btn_q;
  assign count_zero  = ({min_t, min_u, sec_t, sec_u} == 16'h0000);
  assign count_one   = ({min_t, min_u, sec_t, sec_u} == 16'h0001);

  // One-second BCD decrement with borrow rippling from sec_u up to min_t.
  always_comb begin
    dec_mt = min_t;
    dec_mu = min_u;
    dec_st = sec_t;
    dec_su = sec_u;
    if (sec_u != 4'd0) begin
      dec_su = sec_u - 4'd1;
    end else begin
      dec_su = 4'd9;
      if (sec_t != 4'd0) begin
        dec_st = sec_t - 4'd1;
      end else begin
        dec_st = 4'd5;
        if (min_u != 4'd0) begin
          dec_mu = min_u - 4'd1;
        end else begin
          dec_mu = 4'd9;
          dec_mt = min_t - 4'd1;
        end
      end
    end
  end

  // Digit loads depend only on being in SET; set_mode then overrides any other transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      start_btn_q <= 1'b0;
      min_t       <= 4'd0;
      min_u       <= 4'd0;
      sec_t       <= 4'd0;
      sec_u       <= 4'd0;
    end else begin
      start_btn_q <= start_btn;
      if (state == SET) begin
        if (load_a) min_t <= sat9(digit_in);
        if (load_b) min_u <= sat9(digit_in);
        if (load_c) sec_t <= sat5(digit_in);
        if (load_d) sec_u <= sat9(digit_in);
      end
      if (set_mode) begin
        state <= SET;
      end else begin
        case (state)
          IDLE:  state <= IDLE;
          SET:   state <= count_zero ? IDLE : READY;
          READY: if (start_pulse) state <= RUN;
          RUN: begin
            if (start_pulse) begin
              state <= PAUSE;
            end else if (tick_1hz) begin
              // A zero count is never decremented, so 00:00 cannot wrap to 99:59.
              if (!count_zero) begin
                min_t <= dec_mt;
                min_u <= dec_mu;
                sec_t <= dec_st;
                sec_u <= dec_su;
              end
              if (count_one || count_zero) state <= DONE;
            end
          end
          PAUSE: if (start_pulse) state <= RUN;
          DONE:  if (start_pulse) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign running = (state == RUN);
  assign done    = (state == DONE);
  assign state_o = state;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Scenario bench for countdown_ctrl: expected state/count pushed per driven cycle,
// observed values captured after the edge, and both queues drained per scenario.
module tb_countdown_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       set_mode = 1'b0;
  logic       load_a = 1'b0, load_b = 1'b0, load_c = 1'b0, load_d = 1'b0;
  logic [3:0] digit_in = 4'd0;
  logic       start_btn = 1'b0;
  logic [3:0] min_t, min_u, sec_t, sec_u;
  logic       running, done;
  logic [2:0] state_o;

  localparam logic [2:0] S_IDLE = 3'd0, S_SET = 3'd1, S_READY = 3'd2,
                         S_RUN = 3'd3, S_PAUSE = 3'd4, S_DONE = 3'd5;

  typedef struct {
    string       name;
    logic [20:0] v;
  } exp_t;

  exp_t        sb[$];
  logic [20:0] got[$];
  int          total = 0;
  int          bad = 0;

  countdown_ctrl dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .set_mode(set_mode),
    .load_a(load_a), .load_b(load_b), .load_c(load_c), .load_d(load_d),
    .digit_in(digit_in), .start_btn(start_btn),
    .min_t(min_t), .min_u(min_u), .sec_t(sec_t), .sec_u(sec_u),
    .running(running), .done(done), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Expected word: state, running, done, MM:SS; running/done follow from the state.
  function automatic logic [20:0] pack(input logic [2:0] st, input logic [15:0] cnt);
    return {st, (st == S_RUN), (st == S_DONE), cnt};
  endfunction

  function automatic logic [20:0] snap();
    return {state_o, running, done, min_t, min_u, sec_t, sec_u};
  endfunction

  task automatic expect_now(input string name, input logic [2:0] st, input logic [15:0] cnt);
    exp_t e;
    e.name = name;
    e.v    = pack(st, cnt);
    sb.push_back(e);
    got.push_back(snap());
  endtask

  task automatic step(input string name, input logic [2:0] st, input logic [15:0] cnt);
    exp_t e;
    e.name = name;
    e.v    = pack(st, cnt);
    sb.push_back(e);
    @(posedge clk);
    #1;
    got.push_back(snap());
    tick_1hz = 1'b0;
    load_a = 1'b0; load_b = 1'b0; load_c = 1'b0; load_d = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [20:0] o;
    #3;
    expect_now("reset_async", S_IDLE, 16'h0000);
    @(posedge clk); #1;
    reset = 1'b0;
    step("reset_idle", S_IDLE, 16'h0000);
    start_btn = 1'b1;
    step("idle_ignores_start", S_IDLE, 16'h0000);
    start_btn = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = got.pop_front(); total++;
      if (o !== e.v) begin
        bad++;
        $display("[TB] FAIL %s: got st=%0d run=%0b done=%0b cnt=%h, expected st=%0d run=%0b done=%0b cnt=%h",
                 e.name, o[20:18], o[17], o[16], o[15:0], e.v[20:18], e.v[17], e.v[16], e.v[15:0]);
      end
    end
  endtask

  task automatic test_run();
    exp_t e;
    logic [20:0] o;
    logic [15:0] seq [9] = '{16'h0104, 16'h0103, 16'h0102, 16'h0101, 16'h0100,
                             16'h0059, 16'h0058, 16'h0057, 16'h0056};
    set_mode = 1'b1;
    step("run_enter_set", S_SET, 16'h0000);
    load_a = 1'b1; digit_in = 4'd0; step("run_load_a", S_SET, 16'h0000);
    load_b = 1'b1; digit_in = 4'd1; step("run_load_b", S_SET, 16'h0100);
    load_c = 1'b1; digit_in = 4'd0; step("run_load_c", S_SET, 16'h0100);
    load_d = 1'b1; digit_in = 4'd5; step("run_load_d", S_SET, 16'h0105);
    set_mode = 1'b0;
    step("run_ready", S_READY, 16'h0105);
    start_btn = 1'b1; step("run_start", S_RUN, 16'h0105);
    start_btn = 1'b0; step("run_hold", S_RUN, 16'h0105);
    foreach (seq[i]) begin
      tick_1hz = 1'b1;
      step($sformatf("run_tick%0d", i), S_RUN, seq[i]);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = got.pop_front(); total++;
      if (o !== e.v) begin
        bad++;
        $display("[TB] FAIL %s: got st=%0d run=%0b done=%0b cnt=%h, expected st=%0d run=%0b done=%0b cnt=%h",
                 e.name, o[20:18], o[17], o[16], o[15:0], e.v[20:18], e.v[17], e.v[16], e.v[15:0]);
      end
    end
  endtask

  task automatic test_done();
    exp_t e;
    logic [20:0] o;
    set_mode = 1'b1;
    step("done_enter_set", S_SET, 16'h0056);
    load_c = 1'b1; digit_in = 4'd0; step("done_load_c", S_SET, 16'h0006);
    load_d = 1'b1; digit_in = 4'd1; step("done_load_d", S_SET, 16'h0001);
    set_mode = 1'b0;
    step("done_ready", S_READY, 16'h0001);
    start_btn = 1'b1; step("done_start", S_RUN, 16'h0001);
    start_btn = 1'b0; step("done_hold", S_RUN, 16'h0001);
    tick_1hz = 1'b1; step("done_last_tick", S_DONE, 16'h0000);
    tick_1hz = 1'b1; step("done_no_wrap", S_DONE, 16'h0000);
    step("done_hold_zero", S_DONE, 16'h0000);
    start_btn = 1'b1; step("done_to_idle", S_IDLE, 16'h0000);
    start_btn = 1'b0; step("done_idle_hold", S_IDLE, 16'h0000);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = got.pop_front(); total++;
      if (o !== e.v) begin
        bad++;
        $display("[TB] FAIL %s: got st=%0d run=%0b done=%0b cnt=%h, expected st=%0d run=%0b done=%0b cnt=%h",
                 e.name, o[20:18], o[17], o[16], o[15:0], e.v[20:18], e.v[17], e.v[16], e.v[15:0]);
      end
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    logic [20:0] o;
    set_mode = 1'b1;
    step("sat_enter_set", S_SET, 16'h0000);
    load_c = 1'b1; load_d = 1'b1; digit_in = 4'd12; step("sat_sec_12", S_SET, 16'h0059);
    load_a = 1'b1; load_b = 1'b1; digit_in = 4'd10; step("sat_min_10", S_SET, 16'h9959);
    load_c = 1'b1; digit_in = 4'd3; step("sat_sec_t_3", S_SET, 16'h9939);
    load_c = 1'b1; digit_in = 4'd6; step("sat_sec_t_6", S_SET, 16'h9959);
    load_d = 1'b1; digit_in = 4'd15; step("sat_sec_u_15", S_SET, 16'h9959);
    set_mode = 1'b0;
    step("sat_ready", S_READY, 16'h9959);
    load_a = 1'b1; digit_in = 4'd3; step("sat_load_ignored", S_READY, 16'h9959);
    tick_1hz = 1'b1; step("sat_ready_tick", S_READY, 16'h9959);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = got.pop_front(); total++;
      if (o !== e.v) begin
        bad++;
        $display("[TB] FAIL %s: got st=%0d run=%0b done=%0b cnt=%h, expected st=%0d run=%0b done=%0b cnt=%h",
                 e.name, o[20:18], o[17], o[16], o[15:0], e.v[20:18], e.v[17], e.v[16], e.v[15:0]);
      end
    end
  endtask

  task automatic test_pause();
    exp_t e;
    logic [20:0] o;
    start_btn = 1'b1; tick_1hz = 1'b1; step("pause_enter_run_tick", S_RUN, 16'h9959);
    start_btn = 1'b0; tick_1hz = 1'b1; step("pause_run_tick", S_RUN, 16'h9958);
    start_btn = 1'b1; tick_1hz = 1'b1; step("pause_start_tick", S_PAUSE, 16'h9958);
    start_btn = 1'b0; tick_1hz = 1'b1; step("pause_tick_a", S_PAUSE, 16'h9958);
    tick_1hz = 1'b1; step("pause_tick_b", S_PAUSE, 16'h9958);
    start_btn = 1'b1; tick_1hz = 1'b1; step("pause_resume_tick", S_RUN, 16'h9958);
    start_btn = 1'b0; tick_1hz = 1'b1; step("pause_resumed_tick", S_RUN, 16'h9957);
    step("pause_no_tick", S_RUN, 16'h9957);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = got.pop_front(); total++;
      if (o !== e.v) begin
        bad++;
        $display("[TB] FAIL %s: got st=%0d run=%0b done=%0b cnt=%h, expected st=%0d run=%0b done=%0b cnt=%h",
                 e.name, o[20:18], o[17], o[16], o[15:0], e.v[20:18], e.v[17], e.v[16], e.v[15:0]);
      end
    end
  endtask

  task automatic test_borrow();
    exp_t e;
    logic [20:0] o;
    set_mode = 1'b1;
    step("borrow_set_from_run", S_SET, 16'h9957);
    load_a = 1'b1; digit_in = 4'd1; step("borrow_load_a", S_SET, 16'h1957);
    load_b = 1'b1; digit_in = 4'd0; step("borrow_load_b", S_SET, 16'h1057);
    load_c = 1'b1; load_d = 1'b1; digit_in = 4'd0; step("borrow_load_cd", S_SET, 16'h1000);
    set_mode = 1'b0;
    step("borrow_ready", S_READY, 16'h1000);
    start_btn = 1'b1; step("borrow_start", S_RUN, 16'h1000);
    start_btn = 1'b0; step("borrow_hold", S_RUN, 16'h1000);
    tick_1hz = 1'b1; step("borrow_full", S_RUN, 16'h0959);
    tick_1hz = 1'b1; step("borrow_after", S_RUN, 16'h0958);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = got.pop_front(); total++;
      if (o !== e.v) begin
        bad++;
        $display("[TB] FAIL %s: got st=%0d run=%0b done=%0b cnt=%h, expected st=%0d run=%0b done=%0b cnt=%h",
                 e.name, o[20:18], o[17], o[16], o[15:0], e.v[20:18], e.v[17], e.v[16], e.v[15:0]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    logic [20:0] o;
    set_mode = 1'b1;
    step("rst_set", S_SET, 16'h0958);
    load_a = 1'b1; digit_in = 4'd1; step("rst_load_a", S_SET, 16'h1958);
    load_b = 1'b1; load_c = 1'b1; load_d = 1'b1; digit_in = 4'd0; step("rst_load_bcd", S_SET, 16'h1000);
    set_mode = 1'b0;
    step("rst_ready", S_READY, 16'h1000);
    start_btn = 1'b1; step("rst_start", S_RUN, 16'h1000);
    start_btn = 1'b0; step("rst_run", S_RUN, 16'h1000);
    #1;
    reset = 1'b1;
    #1;
    expect_now("rst_async_mid_run", S_IDLE, 16'h0000);
    #1;
    reset = 1'b0;
    tick_1hz = 1'b1; step("rst_idle_tick", S_IDLE, 16'h0000);
    start_btn = 1'b1; step("rst_idle_start", S_IDLE, 16'h0000);
    start_btn = 1'b0; step("rst_idle_hold", S_IDLE, 16'h0000);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = got.pop_front(); total++;
      if (o !== e.v) begin
        bad++;
        $display("[TB] FAIL %s: got st=%0d run=%0b done=%0b cnt=%h, expected st=%0d run=%0b done=%0b cnt=%h",
                 e.name, o[20:18], o[17], o[16], o[15:0], e.v[20:18], e.v[17], e.v[16], e.v[15:0]);
      end
    end
  endtask

  task automatic test_zero_set();
    exp_t e;
    logic [20:0] o;
    set_mode = 1'b1;
    step("zero_set", S_SET, 16'h0000);
    set_mode = 1'b0;
    step("zero_to_idle", S_IDLE, 16'h0000);
    start_btn = 1'b1; step("zero_idle_start", S_IDLE, 16'h0000);
    start_btn = 1'b0; step("zero_idle_hold", S_IDLE, 16'h0000);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = got.pop_front(); total++;
      if (o !== e.v) begin
        bad++;
        $display("[TB] FAIL %s: got st=%0d run=%0b done=%0b cnt=%h, expected st=%0d run=%0b done=%0b cnt=%h",
                 e.name, o[20:18], o[17], o[16], o[15:0], e.v[20:18], e.v[17], e.v[16], e.v[15:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_done();
    test_saturation();
    test_pause();
    test_borrow();
    test_reset_mid_run();
    test_zero_set();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/countdown_ctrl.md
COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: tick_1hz  input  1  one-clk-wide pulse, once per second.
REQ-004 SHALL have port: set_mode  input  1  level; high = user entering digits.
REQ-005 SHALL have port: load_a, load_b, load_c, load_d  input  1 each  one-cycle strobes from digit-entry logic.
REQ-006 SHALL have port: digit_in  input  4  BCD value qualified by any load_x strobe.
REQ-007 SHALL have port: start_btn  input  1  debounced level; rising edge = start/pause request.
REQ-008 SHALL have port: min_t, min_u, sec_t, sec_u  output  4 each  registered BCD count MM:SS (a = min_t, b = min_u, c = sec_t, d = sec_u).
REQ-009 SHALL have port: running  output  1  high exactly when state = RUN.
REQ-010 SHALL have port: done  output  1  high exactly when state = DONE.
REQ-011 SHALL have port: state_o  output  3  current state encoding, for debug.

Function
REQ-012 SHALL implement states IDLE=0, SET=1, READY=2, RUN=3, PAUSE=4, DONE=5; codes 6-7 SHALL go to IDLE on the next edge.
REQ-013 SHALL detect start edge internally: start_pulse = start_btn & ~start_btn_q, with start_btn_q registered and reset to 0.
REQ-014 SHALL give set_mode=1 top priority: from any state, next state = SET.
REQ-015 In SET, load_a/b/c/d SHALL write digit_in into min_t/min_u/sec_t/sec_u on the same edge; multiple strobes in one cycle SHALL all write.
REQ-016 Loads SHALL saturate: min_t, min_u, sec_u values >9 store 9; sec_t values >5 store 5.
REQ-017 load_x strobes outside SET SHALL be ignored.
REQ-018 SET with set_mode=0 SHALL go to READY if count != 00:00, else to IDLE.
REQ-019 READY with start_pulse SHALL go to RUN; IDLE SHALL ignore start_pulse.
REQ-020 RUN with start_pulse SHALL go to PAUSE with no decrement that cycle, even if tick_1hz is high.
REQ-021 RUN with tick_1hz and no start_pulse SHALL decrement MM:SS by one second in BCD on that edge.
REQ-022 Decrement rule: sec_u>0 -> sec_u-1; else sec_u=9 and borrow. Borrow into sec_t: >0 -> -1, else 5 and borrow. Borrow into min_u: >0 -> -1, else 9 and borrow. Borrow into min_t: -1.
REQ-023 A tick that makes the count 00:00 SHALL move RUN to DONE on the same edge; done is high the cycle after that tick.
REQ-024 Count 00:00 SHALL never be decremented; no wrap to 99:59 is permitted.
REQ-025 PAUSE SHALL ignore tick_1hz and hold the count; start_pulse SHALL return to RUN.
REQ-026 DONE SHALL hold the count at 00:00; start_pulse SHALL go to IDLE.
REQ-027 A tick arriving in the cycle the FSM enters RUN from READY or PAUSE SHALL be ignored; decrement applies only when the registered state is RUN.
REQ-028 All outputs SHALL be registered or decoded only from registered state; no combinational path from inputs to outputs.

Reset
REQ-029 reset SHALL asynchronously force state=IDLE, all four digits=0, start_btn_q=0, running=0, done=0.
REQ-030 reset asserted mid-RUN SHALL discard the count; after release the block SHALL stay in IDLE until set_mode rises.

Verification
REQ-031 Load 0,1,0,5 in SET, drop set_mode, pulse start, apply 5 ticks -> count 01:00 then 00:59, 00:58, 00:57, 00:56, running=1 throughout.
REQ-032 Load 00:01, start, apply 1 tick -> count 00:00, done=1, running=0 next cycle; further ticks leave 00:00; start_pulse -> IDLE.
REQ-033 Load digit_in=12 on load_c and load_d -> sec_t=5, sec_u=9.
REQ-034 In RUN, raise start_btn in the same cycle as tick_1hz -> PAUSE, count unchanged; ticks in PAUSE -> no change; second start_pulse -> RUN.
REQ-035 Leave SET with all digits 0 -> IDLE; start_pulse -> stays IDLE.
REQ-036 Assert reset during RUN at 10:00 -> outputs 00:00, state_o=0 immediately, without waiting for a clock edge.
